seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment display driver, next generation of the board's 8-digit tube driver.
//  Scans NUM_DIGITS digits and shows a DATA_W-bit value in hex or unsigned decimal.
//  Decimal uses an iterative double-dabble converter. Adds leading-zero blanking, per-digit decimal points and overflow indication.
//  Sits between the CPU's MMIO seg register and the board's seg_en/seg_out pins.
// PARAMETERS
//  DATA_W      32       width of data_in (8..32)
//  NUM_DIGITS  8        number of physical digits (1..8)
//  SCAN_DIV    100000   clk cycles each digit stays enabled (>=1)
//  SEG_ACT_LO  1        1: seg_out segments active-low
//  EN_ACT_LO   1        1: seg_en digit enables active-low
// PORTS
//  clk      in   1           system clock
//  rst_n    in   1           asynchronous active-low reset
//  data_in  in   DATA_W      value to display
//  mode     in   1           0 = hex, 1 = unsigned decimal
//  dp_in    in   NUM_DIGITS  decimal point per digit (bit i -> digit i, digit 0 = rightmost)
//  lz_blank in   1           1 = suppress leading zeros
//  seg_en   out  NUM_DIGITS  one-hot digit enable (registered)
//  seg_out  out  8           {dp,g,f,e,d,c,b,a} (registered)
// BEHAVIOUR
//  Reset: async on rst_n low.
//   - seg_en all inactive; seg_out all segments off.
//   - FSM = IDLE; scan index = 0; divider = 0.
//   - Display regs = 0 (all digits '0', no dp).
//  Converter FSM (free-running refresh):
//   - IDLE: capture data_in, mode, dp_in, lz_blank. Go to DONE if mode = 0, else SHIFT.
//   - SHIFT: exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left 1 bit.
//     BCD width = (DATA_W*3/10 + 1) nibbles.
//   - DONE: write the result into the display regs atomically, then go to IDLE.
//   - Latency, capture edge to display-reg update: hex 1 cycle; decimal DATA_W+1 cycles.
//   - seg_out reflects a display-reg change on the next edge at which that digit is enabled.
//   - data_in changes outside the capture edge are ignored until the next IDLE.
//  Hex: digit i = nibble i. Nibbles beyond DATA_W/4 read as 0.
//  Decimal overflow: if value >= 10**NUM_DIGITS (any nonzero BCD nibble at or above index NUM_DIGITS),
//   every digit shows '-' with no dp. Blanking is ignored.
//  Leading-zero blanking: digits above the highest nonzero digit are blank (dp still honoured).
//   Digit 0 is never blanked, so value 0 shows '0'.
//  Scan:
//   - Divider counts 0..SCAN_DIV-1. At the terminal count, scan index increments, wrapping NUM_DIGITS-1 -> 0.
//   - seg_en and seg_out update on the same edge, so exactly one enable is active at any time after the first scan edge.
//   - First enable (digit 0) appears SCAN_DIV cycles after reset release.
//  Glyphs (active-high, before polarity):
//   - digits 0-7: 3F 06 5B 4F 66 6D 7D 07
//   - digits 8-F: 7F 6F 77 7C 39 5E 79 71
//   - '-' = 40; blank = 00. dp = bit 7.
//  Polarity: invert seg_out if SEG_ACT_LO; invert seg_en if EN_ACT_LO.
//  Reset mid-SHIFT: conversion aborts and display regs clear. After release, the next IDLE captures fresh.
// TESTING
//  (default widths, SCAN_DIV=4, active-low)
//  1. Reset:
//   - during rst_n=0: seg_en=FF, seg_out=FF.
//   - after release, 4 cycles: seg_en=FE, seg_out=C0 ('0').
//  2. Hex scan: mode=0, data_in=32'h1234ABCD, lz_blank=0.
//   - digits 7..0 show 1 2 3 4 A b C d, i.e. ~{06,5B,4F,66,77,7C,39,5E}.
//   - seg_en walks FE,FD,..,7F then wraps to FE after 32 cycles.
//  3. Decimal: mode=1, data_in=32'd12345678, dp_in=8'h10.
//   - display regs update 33 cycles after capture.
//   - digits show 1 2 3 4 5 6 7 8; digit 4 has dp lit (seg_out=~(66|80)).
//  4. Overflow: data_in=32'd99999999 shows 99999999; data_in=32'd100000000 shows '-' on all 8 digits (seg_out=BF).
//  5. Blanking: mode=1, lz_blank=1.
//   - data_in=42: digits 7..2 = FF, digit 1 = '4', digit 0 = '2'.
//   - data_in=0: only digit 0 = C0.
//  6. rst_n pulsed low at cycle 10 of SHIFT: outputs go to reset values immediately; the next conversion of 32'd7 displays '7' correctly.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus between the CPU-side seg register and the 7-segment scan driver.
// The master drives the value/format controls; the slave drives the pins.
interface seg7_scan_driver_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
);
    logic [DATA_W-1:0]     data_in;
    logic                  mode;
    logic [NUM_DIGITS-1:0] dp_in;
    logic                  lz_blank;
    logic [NUM_DIGITS-1:0] seg_en;
    logic [7:0]            seg_out;

    modport master (
        output data_in, mode, dp_in, lz_blank,
        input  seg_en, seg_out
    );

    modport slave (
        input  data_in, mode, dp_in, lz_blank,
        output seg_en, seg_out
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver. A free-running converter samples the
// bus value, optionally converts it to BCD with an iterative double-dabble,
// and loads the display registers in one step. A divider then walks the
// digit enables and presents each digit's glyph on the same edge.
module seg7_scan_driver #(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int SEG_ACT_LO = 1,
    parameter int EN_ACT_LO  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int BCD_N = DATA_W * 3 / 10 + 1;
    localparam int BCD_W = BCD_N * 4;
    localparam int DIG_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SEG_OFF = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF =
        (EN_ACT_LO != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DATA_W-1:0]     shift_r;
    logic [BCD_W-1:0]      bcd_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  mode_r;
    logic [NUM_DIGITS-1:0] dp_r;
    logic                  lz_r;
    logic [DIG_W-1:0]      disp_val_r;
    logic [NUM_DIGITS-1:0] disp_dp_r;
    logic                  disp_ovf_r;
    logic                  disp_lz_r;
    logic [DIV_W-1:0]      div_r;
    logic [IDX_W-1:0]      idx_r;
    logic [NUM_DIGITS-1:0] seg_en_r;
    logic [7:0]            seg_out_r;
    logic                  ovf_s;
    logic [3:0]            digit_s;
    logic                  higher_nz_s;
    logic                  blank_s;
    logic [7:0]            glyph_s;

    // Active-high segment pattern {g..a} for one hex digit.
    function automatic logic [7:0] hex_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'h0: g = 8'h3F;
            4'h1: g = 8'h06;
            4'h2: g = 8'h5B;
            4'h3: g = 8'h4F;
            4'h4: g = 8'h66;
            4'h5: g = 8'h6D;
            4'h6: g = 8'h7D;
            4'h7: g = 8'h07;
            4'h8: g = 8'h7F;
            4'h9: g = 8'h6F;
            4'hA: g = 8'h77;
            4'hB: g = 8'h7C;
            4'hC: g = 8'h39;
            4'hD: g = 8'h5E;
            4'hE: g = 8'h79;
            4'hF: g = 8'h71;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = b;
        for (int k = 0; k < BCD_N; k++) begin
            nib = b[4*k +: 4];
            if (nib >= 4'd5) begin
                r[4*k +: 4] = nib + 4'd3;
            end else begin
                r[4*k +: 4] = nib;
            end
        end
        return r;
    endfunction

    // Converter next-state: hex skips straight to DONE, decimal shifts DATA_W times.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.mode) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // A decimal result overflows when any BCD nibble lies beyond the visible digits.
    always_comb begin
        ovf_s = mode_r && ((bcd_r >> DIG_W) != {BCD_W{1'b0}});
    end

    // Capture, shift-and-add conversion, and atomic display-register load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= {DATA_W{1'b0}};
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            mode_r     <= 1'b0;
            dp_r       <= {NUM_DIGITS{1'b0}};
            lz_r       <= 1'b0;
            disp_val_r <= {DIG_W{1'b0}};
            disp_dp_r  <= {NUM_DIGITS{1'b0}};
            disp_ovf_r <= 1'b0;
            disp_lz_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    shift_r <= bus.data_in;
                    bcd_r   <= {BCD_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    mode_r  <= bus.mode;
                    dp_r    <= bus.dp_in;
                    lz_r    <= bus.lz_blank;
                end
                ST_SHIFT: begin
                    bcd_r   <= (dabble_adj(bcd_r) << 1) | BCD_W'(shift_r[DATA_W-1]);
                    shift_r <= shift_r << 1;
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                ST_DONE: begin
                    disp_val_r <= mode_r ? DIG_W'(bcd_r) : DIG_W'(shift_r);
                    disp_dp_r  <= dp_r;
                    disp_ovf_r <= ovf_s;
                    disp_lz_r  <= lz_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Glyph for the digit about to be enabled, including blanking and overflow.
    always_comb begin
        digit_s     = disp_val_r[4*idx_r +: 4];
        higher_nz_s = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((IDX_W'(k) > idx_r) && (disp_val_r[4*k +: 4] != 4'd0)) begin
                higher_nz_s = 1'b1;
            end else begin
                higher_nz_s = higher_nz_s;
            end
        end
        blank_s = disp_lz_r && (idx_r != {IDX_W{1'b0}}) &&
                  (digit_s == 4'd0) && !higher_nz_s;
        if (disp_ovf_r) begin
            glyph_s = 8'h40;
        end else if (blank_s) begin
            glyph_s = {disp_dp_r[idx_r], 7'h00};
        end else begin
            glyph_s = hex_glyph(digit_s) | {disp_dp_r[idx_r], 7'h00};
        end
    end

    // Scan divider: on the terminal count present the current digit and advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= {DIV_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            seg_en_r  <= EN_OFF;
            seg_out_r <= SEG_OFF;
        end else if (div_r == DIV_W'(SCAN_DIV - 1)) begin
            div_r     <= {DIV_W{1'b0}};
            idx_r     <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            seg_en_r  <= (NUM_DIGITS'(1) << idx_r) ^ EN_OFF;
            seg_out_r <= glyph_s ^ SEG_OFF;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    assign bus.seg_en  = seg_en_r;
    assign bus.seg_out = seg_out_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes the expected scan
// sequence, a monitor pops one entry each time the digit enable moves.
module tb_seg7_scan_driver;
    logic clk;
    logic rst_n;

    seg7_scan_driver_if #(.DATA_W(32), .NUM_DIGITS(8)) bus ();

    seg7_scan_driver #(
        .DATA_W(32), .NUM_DIGITS(8), .SCAN_DIV(4), .SEG_ACT_LO(1), .EN_ACT_LO(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] out;
        logic [3:0] dig;
    } exp_t;

    exp_t  exp_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    string cur_tag = "reset";

    logic [7:0] GLY [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the display", name);
    endtask

    // Reference: active-low seg_out for digit i, from decimal/hex arithmetic.
    function automatic logic [7:0] ref_out(input int i, input longint unsigned v,
                                           input bit m, input logic [7:0] dp, input bit lz);
        logic [3:0]       d [8];
        longint unsigned  t;
        int               hi;
        logic [7:0]       g;
        t = v;
        if (m && v >= 64'd100000000) return ~8'h40;
        for (int k = 0; k < 8; k++) begin
            if (m) begin
                d[k] = 4'(t % 10);
                t = t / 10;
            end else begin
                d[k] = 4'((v >> (4 * k)) & 64'hF);
            end
        end
        hi = 0;
        for (int k = 0; k < 8; k++) if (d[k] != 4'd0) hi = k;
        g = (lz && i > hi) ? 8'h00 : GLY[d[i]];
        if (dp[i]) g = g | 8'h80;
        return ~g;
    endfunction

    // Monitor: every change of seg_en is one presented digit.
    initial begin
        logic [7:0] prev;
        exp_t       e;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.seg_en !== prev) begin
                prev = bus.seg_en;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_en_d%0d", cur_tag, e.dig), bus.seg_en, e.en);
                    chk($sformatf("%s_out_d%0d", cur_tag, e.dig), bus.seg_out, e.out);
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            timeout_fail(tag);
            exp_q.delete();
        end
    endtask

    task automatic apply(input longint unsigned v, input bit m, input logic [7:0] dp, input bit lz);
        @(negedge clk);
        bus.data_in  = 32'(v);
        bus.mode     = m;
        bus.dp_in    = dp;
        bus.lz_blank = lz;
    endtask

    // Full scan sweep, digits 0..7 then the wrap back to digit 0.
    task automatic sweep(input string tag, input longint unsigned v, input bit m,
                         input logic [7:0] dp, input bit lz);
        int   n;
        exp_t e;
        repeat (80) @(posedge clk);
        @(negedge clk);
        n = 0;
        while (bus.seg_en !== 8'h7F && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.seg_en !== 8'h7F) begin
            timeout_fail({tag, "_sync"});
        end else begin
            @(posedge clk);
            cur_tag = tag;
            for (int k = 0; k < 9; k++) begin
                e.dig = 4'(k % 8);
                e.en  = ~(8'h01 << (k % 8));
                e.out = ref_out(k % 8, v, m, dp, lz);
                exp_q.push_back(e);
            end
            drain(tag);
        end
    endtask

    initial begin
        longint unsigned v;
        bit              m;
        bit              lz;
        logic [7:0]      dp;
        exp_t            e;

        rst_n        = 1'b0;
        bus.data_in  = 32'd0;
        bus.mode     = 1'b0;
        bus.dp_in    = 8'h00;
        bus.lz_blank = 1'b0;

        // Reset values and first scan edge timing.
        repeat (3) @(negedge clk);
        chk("rst_en", bus.seg_en, 8'hFF);
        chk("rst_out", bus.seg_out, 8'hFF);
        e.dig = 4'd0; e.en = 8'hFE; e.out = 8'hC0;
        exp_q.push_back(e);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("pre_first_scan_en", bus.seg_en, 8'hFF);
        @(posedge clk);
        #1 chk("first_scan_en", bus.seg_en, 8'hFE);
        drain("reset");

        // Directed cases.
        apply(64'h1234ABCD, 1'b0, 8'h00, 1'b0);
        sweep("hex", 64'h1234ABCD, 1'b0, 8'h00, 1'b0);
        apply(64'd12345678, 1'b1, 8'h10, 1'b0);
        sweep("dec", 64'd12345678, 1'b1, 8'h10, 1'b0);
        apply(64'd99999999, 1'b1, 8'h00, 1'b0);
        sweep("dec_max", 64'd99999999, 1'b1, 8'h00, 1'b0);
        apply(64'd100000000, 1'b1, 8'h00, 1'b0);
        sweep("dec_ovf", 64'd100000000, 1'b1, 8'h00, 1'b0);
        apply(64'd42, 1'b1, 8'h00, 1'b1);
        sweep("blank42", 64'd42, 1'b1, 8'h00, 1'b1);
        apply(64'd0, 1'b1, 8'h00, 1'b1);
        sweep("blank0", 64'd0, 1'b1, 8'h00, 1'b1);

        // Reset in the middle of a decimal conversion.
        apply(64'd12345678, 1'b1, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_en", bus.seg_en, 8'hFF);
        chk("rst_mid_out", bus.seg_out, 8'hFF);
        bus.data_in = 32'd7;
        @(negedge clk);
        rst_n = 1'b1;
        sweep("after_rst", 64'd7, 1'b1, 8'h00, 1'b0);

        // Randomized cases.
        for (int it = 0; it < 12; it++) begin
            m  = 1'($urandom_range(0, 1));
            lz = 1'($urandom_range(0, 1));
            dp = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       v = 64'($urandom);
                1:       v = 64'($urandom_range(0, 99999999));
                2:       v = 64'($urandom_range(0, 999));
                default: v = (it % 2 == 0) ? 64'd100000000 : 64'd99999999;
            endcase
            apply(v, m, dp, lz);
            sweep($sformatf("rand%0d", it), v, m, dp, lz);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
